serial_divisibility_checker: RTL and testbench

- Bit-serial divisibility checker generalised to any constant divisor `DIVISOR`, with MSB-first or LSB-first operand order.
- Accepts one bit per valid cycle, grouped into fixed-length frames.
- Exposes a running remainder and divisibility flag after every accepted bit.
- At the end of each frame, latches the frame result and pulses a done strobe.
- Used as the serial-residue front end wherever streamed operands are checked modulo a small constant.

---
 rtl/serial_divisibility_checker.sv | 132 +++++++++++++
 tb/tb_serial_divisibility_checker.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_divisibility_checker.sv
// -----------------------------------------------------------------------------
// serial_divisibility_checker
//
// Bit-serial residue checker for a constant modulus DIVISOR. Operand bits
// arrive one per valid cycle, MSB-first or LSB-first, grouped into frames of
// FRAME_LEN bits. A running remainder is exposed after every accepted bit, and
// the remainder of each completed frame is latched alongside a done strobe.
//
// Ports:
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   in_valid        in_bit carries a data bit this cycle
//   in_bit          serial operand bit
//   in_start        with in_valid: this bit opens a new frame
//   lsb_first       operand order, sampled on a start beat (0 = MSB-first)
//   rem             running remainder of the current frame
//   divisible       rem == 0
//   bit_count       bits accepted in the current frame
//   frame_done      one-cycle pulse after the frame's last bit is accepted
//   frame_rem       remainder of the last completed frame
//   frame_divisible frame_rem == 0
//   err             sticky: valid bit arrived with no frame open
// -----------------------------------------------------------------------------
module serial_divisibility_checker #(
    parameter int DIVISOR   = 3,
    parameter int FRAME_LEN = 20,
    localparam int REM_W    = $clog2(DIVISOR),
    localparam int CNT_W    = $clog2(FRAME_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             in_start,
    input  logic             lsb_first,
    output logic [REM_W-1:0] rem,
    output logic             divisible,
    output logic [CNT_W-1:0] bit_count,
    output logic             frame_done,
    output logic [REM_W-1:0] frame_rem,
    output logic             frame_divisible,
    output logic             err
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [REM_W:0]   MOD      = (REM_W + 1)'(DIVISOR);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    state_t           state;
    logic             lsb_mode;
    logic [REM_W-1:0] w;

    logic             start_beat;
    logic             use_lsb;
    logic [REM_W-1:0] base_r;
    logic [REM_W-1:0] base_w;
    logic [REM_W:0]   msb_sum;
    logic [REM_W:0]   lsb_sum;
    logic [REM_W:0]   sum;
    logic [REM_W:0]   w_dbl;
    logic [REM_W-1:0] r_next;
    logic [REM_W-1:0] w_next;

    // Next remainder/weight for the bit on the inputs. A start beat restarts
    // from r=0, w=1 and uses the freshly presented order, so the same datapath
    // serves both the first bit of a frame and the bits that follow. Every sum
    // is below 2*DIVISOR, so one conditional subtract keeps it in range.
    always_comb begin
        start_beat = in_valid & in_start;
        base_r     = start_beat ? '0 : rem;
        base_w     = start_beat ? REM_W'(1) : w;
        use_lsb    = start_beat ? lsb_first : lsb_mode;
        msb_sum    = {base_r, 1'b0} + {{REM_W{1'b0}}, in_bit};
        lsb_sum    = {1'b0, base_r} + (in_bit ? {1'b0, base_w} : '0);
        sum        = use_lsb ? lsb_sum : msb_sum;
        r_next     = (sum >= MOD) ? REM_W'(sum - MOD) : sum[REM_W-1:0];
        w_dbl      = {base_w, 1'b0};
        w_next     = (w_dbl >= MOD) ? REM_W'(w_dbl - MOD) : w_dbl[REM_W-1:0];
    end

    // Frame control. A start beat wins in any state, which abandons an open
    // frame without a done pulse. Bits outside a frame only raise err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            lsb_mode   <= 1'b0;
            w          <= REM_W'(1);
            rem        <= '0;
            bit_count  <= '0;
            frame_done <= 1'b0;
            frame_rem  <= '0;
            err        <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (start_beat) begin
                lsb_mode  <= lsb_first;
                rem       <= r_next;
                w         <= use_lsb ? w_next : base_w;
                bit_count <= CNT_W'(1);
                err       <= 1'b0;
                if (FRAME_LEN == 1) begin
                    frame_rem  <= r_next;
                    frame_done <= 1'b1;
                    state      <= IDLE;
                end else begin
                    state <= RUN;
                end
            end else if (in_valid) begin
                if (state == RUN) begin
                    rem       <= r_next;
                    w         <= use_lsb ? w_next : base_w;
                    bit_count <= bit_count + CNT_W'(1);
                    if (bit_count == LAST_IDX) begin
                        frame_rem  <= r_next;
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

    assign divisible       = (rem == '0);
    assign frame_divisible = (frame_rem == '0);

endmodule

// File: tb/tb_serial_divisibility_checker.sv
// -----------------------------------------------------------------------------
// tb_serial_divisibility_checker
//
// Three checker instances: N=3/FRAME_LEN=4, N=5/FRAME_LEN=4, N=3/FRAME_LEN=20.
// Only the instance selected by 'sel' sees in_valid. Each driven cycle pushes
// the hand-computed expected outputs; a monitor pops and compares one cycle
// later, #1 after the accepting clock edge.
// -----------------------------------------------------------------------------
module tb_serial_divisibility_checker;

    typedef struct {
        int sel;
        int erem;
        int ecnt;
        bit eerr;
        bit edone;
        int efrem;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic in_bit = 1'b0;
    logic in_start = 1'b0;
    logic lsb_first = 1'b0;
    int   sel = 0;

    logic va, vb, vc;
    assign va = in_valid && (sel == 0);
    assign vb = in_valid && (sel == 1);
    assign vc = in_valid && (sel == 2);

    logic [1:0] a_rem, a_frem;
    logic [2:0] a_cnt;
    logic       a_div, a_done, a_fdiv, a_err;
    logic [2:0] b_rem, b_frem;
    logic [2:0] b_cnt;
    logic       b_div, b_done, b_fdiv, b_err;
    logic [1:0] c_rem, c_frem;
    logic [4:0] c_cnt;
    logic       c_div, c_done, c_fdiv, c_err;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    serial_divisibility_checker #(.DIVISOR(3), .FRAME_LEN(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(va), .in_bit(in_bit),
        .in_start(in_start), .lsb_first(lsb_first), .rem(a_rem),
        .divisible(a_div), .bit_count(a_cnt), .frame_done(a_done),
        .frame_rem(a_frem), .frame_divisible(a_fdiv), .err(a_err)
    );

    serial_divisibility_checker #(.DIVISOR(5), .FRAME_LEN(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(vb), .in_bit(in_bit),
        .in_start(in_start), .lsb_first(lsb_first), .rem(b_rem),
        .divisible(b_div), .bit_count(b_cnt), .frame_done(b_done),
        .frame_rem(b_frem), .frame_divisible(b_fdiv), .err(b_err)
    );

    serial_divisibility_checker #(.DIVISOR(3), .FRAME_LEN(20)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(vc), .in_bit(in_bit),
        .in_start(in_start), .lsb_first(lsb_first), .rem(c_rem),
        .divisible(c_div), .bit_count(c_cnt), .frame_done(c_done),
        .frame_rem(c_frem), .frame_divisible(c_fdiv), .err(c_err)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input int exp_val);
        checks++;
        if (act !== exp_val) begin
            errors++;
            $display("[TB] FAIL %s (dut %0d): got %0d expected %0d at %0t", name, sel, act, exp_val, $time);
        end
    endtask

    // Drive one cycle of inputs and queue what the selected instance must show
    // after the next rising edge. rst pulses rst_n low between clock edges.
    task automatic applyStimulus(input bit v, input bit st, input bit b, input bit l,
                                 input int erem, input int ecnt, input bit eerr,
                                 input bit edone, input int efrem, input bit rst = 1'b0);
        exp_t e;
        @(posedge clk);
        #2;
        in_valid  = v;
        in_start  = st;
        in_bit    = b;
        lsb_first = l;
        e.sel   = sel;
        e.erem  = erem;
        e.ecnt  = ecnt;
        e.eerr  = eerr;
        e.edone = edone;
        e.efrem = efrem;
        sb.push_back(e);
        if (rst) begin
            rst_n = 1'b0;
            #2;
            rst_n = 1'b1;
        end
    endtask

    // Monitor: compares the selected instance against the oldest queued entry
    initial begin
        exp_t e;
        logic [31:0] ar, ac, afr;
        logic ad, ae, ado, afd;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                case (e.sel)
                    0: begin
                        ar = 32'(a_rem); ac = 32'(a_cnt); afr = 32'(a_frem);
                        ad = a_div; ae = a_err; ado = a_done; afd = a_fdiv;
                    end
                    1: begin
                        ar = 32'(b_rem); ac = 32'(b_cnt); afr = 32'(b_frem);
                        ad = b_div; ae = b_err; ado = b_done; afd = b_fdiv;
                    end
                    default: begin
                        ar = 32'(c_rem); ac = 32'(c_cnt); afr = 32'(c_frem);
                        ad = c_div; ae = c_err; ado = c_done; afd = c_fdiv;
                    end
                endcase
                checkOutput("rem", ar, e.erem);
                checkOutput("divisible", 32'(ad), (e.erem == 0) ? 1 : 0);
                checkOutput("bit_count", ac, e.ecnt);
                checkOutput("err", 32'(ae), int'(e.eerr));
                checkOutput("frame_done", 32'(ado), int'(e.edone));
                checkOutput("frame_rem", afr, e.efrem);
                checkOutput("frame_divisible", 32'(afd), (e.efrem == 0) ? 1 : 0);
            end
        end
    end

    initial begin
        longint val;
        bit     rb;
        int     r3;

        #22;
        rst_n = 1'b1;

        // Reset values on the N=3 / 4-bit instance
        sel = 0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // MSB-first 1011 = 11 -> rem 1,2,2,2; frame_rem 2
        applyStimulus(1, 1, 1, 0, 1, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 2, 2, 0, 0, 0);
        applyStimulus(1, 0, 1, 0, 2, 3, 0, 0, 0);
        applyStimulus(1, 0, 1, 0, 2, 4, 0, 1, 2);
        applyStimulus(0, 0, 0, 0, 2, 4, 0, 0, 2);

        // Bit with no frame open: err set, rem/bit_count held; start clears err
        applyStimulus(1, 0, 1, 0, 2, 4, 1, 0, 2);
        applyStimulus(0, 0, 0, 0, 2, 4, 1, 0, 2);
        applyStimulus(1, 1, 1, 0, 1, 1, 0, 0, 2);
        applyStimulus(1, 0, 0, 0, 2, 2, 0, 0, 2);
        // Restart after two bits
        applyStimulus(1, 1, 1, 0, 1, 1, 0, 0, 2);
        applyStimulus(1, 0, 1, 0, 0, 2, 0, 0, 2);
        applyStimulus(1, 0, 0, 0, 0, 3, 0, 0, 2);
        // Start coincident with what would be the final bit: no frame_done
        applyStimulus(1, 1, 1, 0, 1, 1, 0, 0, 2);
        // in_start without in_valid does nothing
        applyStimulus(0, 1, 1, 0, 1, 1, 0, 0, 2);
        applyStimulus(1, 0, 0, 0, 2, 2, 0, 0, 2);
        // Reset pulse between edges mid-frame; the frame is gone afterwards
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1);
        applyStimulus(1, 0, 1, 0, 0, 0, 1, 0, 0);
        applyStimulus(1, 0, 1, 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);

        // LSB-first 1,0,1,1 = 13 -> rem 1,1,2,1; lsb_first toggled mid-frame
        applyStimulus(1, 1, 1, 1, 1, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 1, 2, 0, 0, 0);
        applyStimulus(1, 0, 1, 0, 2, 3, 0, 0, 0);
        applyStimulus(1, 0, 1, 0, 1, 4, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 1, 4, 0, 0, 1);
        // MSB-first 1100 = 12 -> frame_rem 0
        applyStimulus(1, 1, 1, 0, 1, 1, 0, 0, 1);
        applyStimulus(1, 0, 1, 1, 0, 2, 0, 0, 1);
        applyStimulus(1, 0, 0, 1, 0, 3, 0, 0, 1);
        applyStimulus(1, 0, 0, 1, 0, 4, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 4, 0, 0, 0);

        // N=5, MSB-first 1,0,<3-cycle stall>,1,0 -> rem 1,2,2,2,2,0,0
        sel = 1;
        applyStimulus(1, 1, 1, 0, 1, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 2, 2, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 2, 2, 0, 0, 0);
        applyStimulus(1, 0, 1, 0, 0, 3, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 4, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 4, 0, 0, 0);

        // N=3, 20-bit frame of seeded random bits against value mod 3
        sel = 2;
        val = 0;
        r3  = 0;
        void'($urandom(2968));
        for (int i = 0; i < 20; i++) begin
            rb  = 1'($urandom_range(0, 1));
            val = val * 2 + longint'(rb);
            r3  = int'(val % 3);
            applyStimulus(1, (i == 0), rb, 0, r3, i + 1, 0, (i == 19), (i == 19) ? r3 : 0);
        end
        applyStimulus(0, 0, 0, 0, r3, 20, 0, 0, r3);
        applyStimulus(1, 0, 1, 0, r3, 20, 1, 0, r3);
        applyStimulus(0, 0, 0, 0, r3, 20, 1, 0, r3);

        repeat (3) @(posedge clk);
        #3;
        checkOutput("scoreboard_drained", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
